adc_block_averager: RTL and testbench
=====================================

# adc_block_averager

- Upstream stage between the ADC AXI-Stream and the LED/threshold decoders.
- Averages each block of 2^LOG2_N consecutive valid ADC samples into one result, which reduces noise and the sample rate.
- Emits each average as a sign-extended AXI-Stream beat with a one-entry output register.
- Flags results that are lost because downstream did not accept them in time.

## Interface
- ADC_WIDTH, 14: width of the two's-complement ADC sample in S_AXIS_tdata[ADC_WIDTH-1:0].
- AXIS_TDATA_WIDTH, 32: input and output tdata width.
- LOG2_N, 2: block length is 2^LOG2_N. Legal range 1..8.
- clk  input  1  sample clock, 125 MHz. One clock only; reset is synchronous and active-low.
- rst  input  1  synchronous active-low reset.
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  ADC sample. Bits above ADC_WIDTH-1 are ignored.
- S_AXIS_tvalid  input  1  sample valid. There is no tready; the block always accepts.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  block average, sign-extended.
- M_AXIS_tvalid  output  1  result valid.
- M_AXIS_tready  input  1  downstream accept.
- ovf  output  1  sticky flag: a result was overwritten before it was accepted.

## Operation
- Accumulator `acc` is signed, ADC_WIDTH+LOG2_N bits. Counter `cnt` is LOG2_N bits.
- Beat with S_AXIS_tvalid=1 and cnt < 2^LOG2_N-1: acc <= acc + sample; cnt <= cnt+1.
- Beat with tvalid=0: acc and cnt hold.
- Last beat of a block (tvalid=1 and cnt = 2^LOG2_N-1):
  - sum = acc + sample.
  - result = sum >>> LOG2_N (arithmetic shift, floor).
  - Result is loaded into the output register; acc <= 0; cnt <= 0.
- The sum cannot overflow: the width ADC_WIDTH+LOG2_N is sufficient, including the rounding addend.
- Output register, on a load:
  - M_AXIS_tdata <= sign-extended result; M_AXIS_tvalid <= 1.
  - If tvalid was already 1 and M_AXIS_tready=0 in that cycle, the old value is overwritten and ovf <= 1.
  - If M_AXIS_tready=1 in the same cycle, the old beat counts as accepted and ovf is unchanged.
- Output register, no load:
  - If M_AXIS_tvalid=1 and M_AXIS_tready=1, then M_AXIS_tvalid <= 0.
  - M_AXIS_tdata holds its last value.
- ovf is cleared only by reset.
- Reset (rst=0, sampled at a clk edge):
  - acc=0, cnt=0, M_AXIS_tdata=0, M_AXIS_tvalid=0, ovf=0.
  - A partial block is discarded. The next valid beat after reset release is sample 0 of a new block.

## Timing
- M_AXIS_tvalid rises on the clk edge that accepts the last sample of a block, so it is visible one cycle after that beat is presented.
- Latency from the last sample to the result is 1 cycle.
- With continuous tvalid, there is at most one result per 2^LOG2_N cycles. The result is a single-cycle pulse when M_AXIS_tready=1.
- M_AXIS_tdata is stable while M_AXIS_tvalid=1 and M_AXIS_tready=0, unless an overwrite occurs (which sets ovf).
- The input path has no combinational dependence on M_AXIS_tready. The block never stalls the ADC.

## Configuration
- ADC_BLOCK_AVG_ROUND_EN defined: result = (sum + 2^(LOG2_N-1)) >>> LOG2_N, i.e. round half toward +infinity.
- Not defined: result = sum >>> LOG2_N, i.e. truncation toward −infinity.
- The macro has no other effect. Latency is identical in both builds.

## Test plan
All tests use ADC_WIDTH=14, LOG2_N=2 (blocks of 4).
- Reset: hold rst=0 for 3 cycles with random input.
  - Required: M_AXIS_tvalid=0, M_AXIS_tdata=0, ovf=0.
- Basic average: samples 100, 200, 300, 400 on consecutive cycles, M_AXIS_tready=1.
  - Required: tdata=250 with tvalid=1 for exactly one cycle, starting one cycle after the 400 beat.
- Rounding:
  - Samples 1, 1, 1, 0 → 0 without macro, 1 with macro.
  - Samples −1, −1, −1, −2 → −2 (0xFFFFFFFE) without macro, −1 with macro.
- Gaps and full scale: samples 8191 ×4 interleaved with tvalid=0 cycles, then −8192 ×4.
  - Required: results 8191 then −8192 (0xFFFFE000). Gap cycles must not advance cnt.
- Backpressure: M_AXIS_tready=0 while blocks averaging 10 and then 20 complete.
  - Required: tdata=20, tvalid=1, ovf=1 sticky.
  - Raise tready for one cycle → tvalid=0 next cycle, ovf remains 1.
- Mid-block reset: samples 5, 7, then rst=0 for one cycle, then 8, 8, 8, 8.
  - Required: a single result of 8 and no result before it.

Source files
------------

// File: rtl/adc_block_averager.sv
// Block averager: sums 2^LOG2_N valid ADC samples and emits the mean as one AXI-Stream beat.
// Define ADC_BLOCK_AVG_ROUND_EN to round half toward +inf instead of truncating toward -inf.
module adc_block_averager #(
    parameter int unsigned ADC_WIDTH        = 14,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LOG2_N           = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        ovf
);

    localparam int unsigned AccWidth = ADC_WIDTH + LOG2_N;

    logic signed [AccWidth-1:0] acc;
    logic        [LOG2_N-1:0]   cnt;
    logic signed [AccWidth-1:0] sample_ext;
    logic signed [AccWidth-1:0] sum;
    logic signed [AccWidth-1:0] sum_rnd;
    logic signed [AccWidth-1:0] result;
    logic                       last;
    logic                       unused_tdata;

    assign unused_tdata = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH];

    always_comb begin
        sample_ext = {{LOG2_N{S_AXIS_tdata[ADC_WIDTH-1]}}, S_AXIS_tdata[ADC_WIDTH-1:0]};
        sum        = acc + sample_ext;
`ifdef ADC_BLOCK_AVG_ROUND_EN
        // Headroom of LOG2_N bits covers the half-LSB addend, so this cannot wrap.
        sum_rnd    = sum + AccWidth'(1 << (LOG2_N - 1));
`else
        sum_rnd    = sum;
`endif
        result     = sum_rnd >>> LOG2_N;
        last       = S_AXIS_tvalid && (cnt == {LOG2_N{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc           <= '0;
            cnt           <= '0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else if (S_AXIS_tvalid) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end

            if (last) begin
                M_AXIS_tdata  <= AXIS_TDATA_WIDTH'(result);
                M_AXIS_tvalid <= 1'b1;
                // An unaccepted beat being replaced is a lost result.
                if (M_AXIS_tvalid && !M_AXIS_tready) begin
                    ovf <= 1'b1;
                end
            end else if (M_AXIS_tvalid && M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_block_averager.sv
// Directed bench for adc_block_averager (ADC_WIDTH=14, LOG2_N=2); honours ADC_BLOCK_AVG_ROUND_EN.
module tb_adc_block_averager;

    logic        clk;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        ovf;

    int errors = 0;
    int checks = 0;

`ifdef ADC_BLOCK_AVG_ROUND_EN
    localparam logic [31:0] ExpSmallPos = 32'd1;
    localparam logic [31:0] ExpSmallNeg = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ExpSmallPos = 32'd0;
    localparam logic [31:0] ExpSmallNeg = 32'hFFFF_FFFE;
`endif

    adc_block_averager #(
        .ADC_WIDTH       (14),
        .AXIS_TDATA_WIDTH(32),
        .LOG2_N          (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_AXIS_tdata (s_tdata),
        .S_AXIS_tvalid(s_tvalid),
        .M_AXIS_tdata (m_tdata),
        .M_AXIS_tvalid(m_tvalid),
        .M_AXIS_tready(m_tready),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Present one input beat, let the edge take it, then settle before sampling outputs.
    task automatic beat(input logic v, input logic [31:0] d);
        s_tvalid = v;
        s_tdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;

        // Reset with random input activity
        for (int i = 0; i < 3; i++) begin
            beat(1'($urandom), $urandom);
        end
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b1;

        // Basic average
        beat(1'b1, 32'd100);
        beat(1'b1, 32'd200);
        beat(1'b1, 32'd300);
        check("basic_no_early", {31'd0, m_tvalid}, 32'd0);
        beat(1'b1, 32'd400);
        check("basic_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("basic_tdata", m_tdata, 32'd250);
        beat(1'b0, 32'd0);
        check("basic_pulse", {31'd0, m_tvalid}, 32'd0);

        // Rounding, positive
        beat(1'b1, 32'd1);
        beat(1'b1, 32'd1);
        beat(1'b1, 32'd1);
        beat(1'b1, 32'd0);
        check("rnd_pos_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("rnd_pos_tdata", m_tdata, ExpSmallPos);

        // Rounding, negative (upper tdata bits carry garbage that must be ignored)
        beat(1'b1, 32'h0000_3FFF);
        beat(1'b1, 32'hFFFF_FFFF);
        beat(1'b1, 32'h1234_3FFF);
        beat(1'b1, 32'h0000_3FFE);
        check("rnd_neg_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("rnd_neg_tdata", m_tdata, ExpSmallNeg);

        // Full-scale positive with gaps
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 32'hABCD_1FFF);
            beat(1'b0, 32'h0000_1FFF);
        end
        check("gap_no_early", {31'd0, m_tvalid}, 32'd0);
        beat(1'b1, 32'h0000_1FFF);
        check("fs_pos_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("fs_pos_tdata", m_tdata, 32'd8191);
        beat(1'b0, 32'd0);

        // Full-scale negative with gaps
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 32'h0000_2000);
            beat(1'b0, 32'h0000_2000);
        end
        check("gap_neg_no_early", {31'd0, m_tvalid}, 32'd0);
        beat(1'b1, 32'hFFFF_2000);
        check("fs_neg_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("fs_neg_tdata", m_tdata, 32'hFFFF_E000);
        beat(1'b0, 32'd0);

        // Backpressure and overwrite
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1'b1, 32'd10);
        check("bp_first_tdata", m_tdata, 32'd10);
        check("bp_first_ovf", {31'd0, ovf}, 32'd0);
        beat(1'b0, 32'd0);
        check("bp_hold_tvalid", {31'd0, m_tvalid}, 32'd1);
        for (int i = 0; i < 4; i++) beat(1'b1, 32'd20);
        check("bp_tdata", m_tdata, 32'd20);
        check("bp_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("bp_ovf", {31'd0, ovf}, 32'd1);
        m_tready = 1'b1;
        beat(1'b0, 32'd0);
        m_tready = 1'b0;
        check("bp_drain_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("bp_ovf_sticky", {31'd0, ovf}, 32'd1);
        check("bp_tdata_hold", m_tdata, 32'd20);
        beat(1'b0, 32'd0);
        check("bp_ovf_sticky2", {31'd0, ovf}, 32'd1);

        // Mid-block reset discards the partial block
        m_tready = 1'b1;
        beat(1'b1, 32'd5);
        beat(1'b1, 32'd7);
        rst = 1'b0;
        beat(1'b0, 32'd0);
        rst = 1'b1;
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        check("mid_rst_tdata", m_tdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 32'd8);
            check("mid_no_early", {31'd0, m_tvalid}, 32'd0);
        end
        beat(1'b1, 32'd8);
        check("mid_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("mid_tdata", m_tdata, 32'd8);
        beat(1'b0, 32'd0);
        check("mid_pulse", {31'd0, m_tvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
